seg7_capture: RTL and testbench

- Reverse of the team's hex-to-7-segment decoder: snoops a multiplexed 7-segment display bus (segment lines plus one-hot digit select) and recovers the hex nibble shown on each digit.
- Filters scan glitches with a stability counter and flags patterns that are not one of the 16 hex glyphs.
- Sits beside the display driver for readback, self-check and board-level verification.

---
 rtl/seg7_capture.sv | 156 +++++++++++++++
 tb/tb_seg7_capture.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// Snoops a multiplexed 7-segment display bus and recovers the hex nibble shown on each digit.
// A pattern is accepted once it has been sampled unchanged on STABLE_CYCLES consecutive edges.
module seg7_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic                  dp,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_valid,
    output logic [DIGITS-1:0]     bad_pattern,
    output logic [DIGITS-1:0]     dp_out,
    output logic                  capture,
    output logic [2:0]            cap_idx,
    output logic                  frame_done
);

    localparam int              SAMP_W  = DIGITS + 8;
    localparam logic [7:0]      CNT_MAX = 8'(STABLE_CYCLES);

    // Returns {legal, nibble}; exact match only.
    function automatic logic [4:0] decode_glyph(input logic [6:0] s);
        case (s)
            7'b1111110: decode_glyph = 5'h10;
            7'b0110000: decode_glyph = 5'h11;
            7'b1101101: decode_glyph = 5'h12;
            7'b1111001: decode_glyph = 5'h13;
            7'b0110011: decode_glyph = 5'h14;
            7'b1011011: decode_glyph = 5'h15;
            7'b1011111: decode_glyph = 5'h16;
            7'b1110000: decode_glyph = 5'h17;
            7'b1111111: decode_glyph = 5'h18;
            7'b1111011: decode_glyph = 5'h19;
            7'b1110111: decode_glyph = 5'h1A;
            7'b0011111: decode_glyph = 5'h1B;
            7'b1001110: decode_glyph = 5'h1C;
            7'b0111101: decode_glyph = 5'h1D;
            7'b1001111: decode_glyph = 5'h1E;
            7'b1000111: decode_glyph = 5'h1F;
            default:    decode_glyph = 5'h00;
        endcase
    endfunction

    logic [SAMP_W-1:0]   samp_d, samp_q;
    logic [7:0]          cnt_d, cnt_q;
    logic [4*DIGITS-1:0] value_d, value_q;
    logic [DIGITS-1:0]   digit_valid_d, digit_valid_q;
    logic [DIGITS-1:0]   bad_pattern_d, bad_pattern_q;
    logic [DIGITS-1:0]   dp_out_d, dp_out_q;
    logic [DIGITS-1:0]   seen_d, seen_q;
    logic                capture_d, capture_q;
    logic [2:0]          cap_idx_d, cap_idx_q;
    logic                frame_done_d, frame_done_q;

    logic                accept;
    logic [2:0]          sel_idx;
    logic [4:0]          glyph;
    logic [DIGITS-1:0]   seen_next;

    // Stability counter: restarts at 1 on any change, saturates so a held pattern fires once.
    always_comb begin
        samp_d = {dig_sel, seg, dp};
        if (samp_d == samp_q) begin
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 8'd1;
        end else begin
            cnt_d = 8'd1;
        end
        accept = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX) && $onehot(dig_sel);
    end

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_sel[i]) sel_idx = 3'(i);
        end
    end

    assign glyph = decode_glyph(seg);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        value_d       = value_q;
        digit_valid_d = digit_valid_q;
        bad_pattern_d = bad_pattern_q;
        dp_out_d      = dp_out_q;
        seen_d        = seen_q;
        capture_d     = 1'b0;
        cap_idx_d     = 3'd0;
        frame_done_d  = 1'b0;
        seen_next     = seen_q | dig_sel;

        if (accept) begin
            capture_d = 1'b1;
            cap_idx_d = sel_idx;
            for (int i = 0; i < DIGITS; i++) begin
                if (dig_sel[i]) begin
                    dp_out_d[i] = dp;
                    if (glyph[4]) begin
                        value_d[4*i +: 4] = glyph[3:0];
                        digit_valid_d[i]  = 1'b1;
                        bad_pattern_d[i]  = 1'b0;
                    end else begin
                        digit_valid_d[i]  = 1'b0;
                        bad_pattern_d[i]  = 1'b1;
                    end
                end
            end
            // Completing the mask closes the frame; the closing digit does not carry over.
            if (&seen_next) begin
                frame_done_d = 1'b1;
                seen_d       = '0;
            end else begin
                seen_d       = seen_next;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q        <= '0;
            cnt_q         <= '0;
            value_q       <= '0;
            digit_valid_q <= '0;
            bad_pattern_q <= '0;
            dp_out_q      <= '0;
            seen_q        <= '0;
            capture_q     <= 1'b0;
            cap_idx_q     <= 3'd0;
            frame_done_q  <= 1'b0;
        end else begin
            samp_q        <= samp_d;
            cnt_q         <= cnt_d;
            value_q       <= value_d;
            digit_valid_q <= digit_valid_d;
            bad_pattern_q <= bad_pattern_d;
            dp_out_q      <= dp_out_d;
            seen_q        <= seen_d;
            capture_q     <= capture_d;
            cap_idx_q     <= cap_idx_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign value       = value_q;
    assign digit_valid = digit_valid_q;
    assign bad_pattern = bad_pattern_q;
    assign dp_out      = dp_out_q;
    assign capture     = capture_q;
    assign cap_idx     = cap_idx_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed scenarios then random scan bursts,
// compared every cycle against a run-length / glyph-table reference model.
module tb_seg7_capture;

    localparam int D = 4;
    localparam int S = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [6:0]     seg = '0;
    logic           dp = 1'b0;
    logic [D-1:0]   dig_sel = '0;
    logic [4*D-1:0] value;
    logic [D-1:0]   digit_valid, bad_pattern, dp_out;
    logic           capture;
    logic [2:0]     cap_idx;
    logic           frame_done;

    seg7_capture #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .dp(dp), .dig_sel(dig_sel),
        .value(value), .digit_valid(digit_valid), .bad_pattern(bad_pattern),
        .dp_out(dp_out), .capture(capture), .cap_idx(cap_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] glyphs [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Reference model state
    logic [D+7:0]   m_prev;
    int             m_run;
    logic [3:0]     m_val [D];
    logic [D-1:0]   m_valid, m_bad, m_dp, m_seen;
    logic           m_cap, m_frame;
    int             m_idx;

    int total = 0;
    int bad = 0;
    int cap_cnt, frm_cnt;

    function automatic int lookup(input logic [6:0] s);
        lookup = -1;
        for (int k = 0; k < 16; k++) if (glyphs[k] == s) lookup = k;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = '0; m_run = 0;
        for (int k = 0; k < D; k++) m_val[k] = 4'h0;
        m_valid = '0; m_bad = '0; m_dp = '0; m_seen = '0;
        m_cap = 1'b0; m_frame = 1'b0; m_idx = 0;
    endtask

    task automatic model_edge();
        logic [D+7:0] cur;
        int g;
        cur = {dig_sel, seg, dp};
        m_run = (cur == m_prev) ? m_run + 1 : 1;
        m_prev = cur;
        m_cap = (m_run == S) && ($countones(dig_sel) == 1);
        m_frame = 1'b0;
        if (m_cap) begin
            for (int k = 0; k < D; k++) if (dig_sel[k]) m_idx = k;
            g = lookup(seg);
            if (g >= 0) begin
                m_val[m_idx] = 4'(g); m_valid[m_idx] = 1'b1; m_bad[m_idx] = 1'b0;
            end else begin
                m_valid[m_idx] = 1'b0; m_bad[m_idx] = 1'b1;
            end
            m_dp[m_idx] = dp;
            m_seen[m_idx] = 1'b1;
            if (m_seen == {D{1'b1}}) begin
                m_frame = 1'b1;
                m_seen = '0;
            end
        end
    endtask

    task automatic compare_all();
        check("capture", 32'(capture), 32'(m_cap));
        check("frame_done", 32'(frame_done), 32'(m_frame));
        check("value", 32'(value), 32'({m_val[3], m_val[2], m_val[1], m_val[0]}));
        check("digit_valid", 32'(digit_valid), 32'(m_valid));
        check("bad_pattern", 32'(bad_pattern), 32'(m_bad));
        check("dp_out", 32'(dp_out), 32'(m_dp));
        if (m_cap) check("cap_idx", 32'(cap_idx), 32'(m_idx));
        cap_cnt += int'(capture);
        frm_cnt += int'(frame_done);
    endtask

    task automatic step(input logic [D-1:0] ds, input logic [6:0] sg, input logic d);
        dig_sel = ds; seg = sg; dp = d;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic hold(input logic [D-1:0] ds, input logic [6:0] sg, input logic d, input int n);
        for (int k = 0; k < n; k++) step(ds, sg, d);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_value"}, 32'(value), 32'h0);
        check({tag, "_valid"}, 32'(digit_valid), 32'h0);
        check({tag, "_bad"}, 32'(bad_pattern), 32'h0);
        check({tag, "_dp"}, 32'(dp_out), 32'h0);
        check({tag, "_ctl"}, 32'({capture, cap_idx, frame_done}), 32'h0);
    endtask

    initial begin
        model_reset();
        #2;
        check_zero("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // 1: long hold captures once on the 4th edge
        cap_cnt = 0; frm_cnt = 0;
        hold(4'b0001, 7'b1111001, 1'b0, 14);
        check("s1_caps", 32'(cap_cnt), 32'd1);
        check("s1_value", 32'(value), 32'h0003);
        check("s1_valid", 32'(digit_valid), 32'b0001);

        // 2: a 3-cycle run is too short; the following 4-cycle run is accepted
        cap_cnt = 0;
        hold(4'b0010, 7'b0110000, 1'b0, 3);
        check("s2_short", 32'(cap_cnt), 32'd0);
        hold(4'b0010, 7'b1101101, 1'b0, 4);
        check("s2_caps", 32'(cap_cnt), 32'd1);
        check("s2_nib", 32'(value[7:4]), 32'h2);

        // 3: full scan
        cap_cnt = 0; frm_cnt = 0;
        hold(4'b0001, 7'b0110000, 1'b0, 6);
        hold(4'b0010, 7'b1110111, 1'b0, 6);
        hold(4'b0100, 7'b0011111, 1'b0, 6);
        check("s3_noframe_yet", 32'(frm_cnt), 32'd0);
        hold(4'b1000, 7'b1000111, 1'b0, 4);
        check("s3_frame_with_d3", 32'({capture, frame_done, cap_idx}), 32'b11011);
        hold(4'b1000, 7'b1000111, 1'b0, 2);
        check("s3_caps", 32'(cap_cnt), 32'd4);
        check("s3_frames", 32'(frm_cnt), 32'd1);
        check("s3_value", 32'(value), 32'hFBA1);
        check("s3_valid", 32'(digit_valid), 32'hF);

        // 4: illegal glyph on digit 2
        cap_cnt = 0;
        hold(4'b0100, 7'b0000001, 1'b0, 5);
        check("s4_caps", 32'(cap_cnt), 32'd1);
        check("s4_bad", 32'(bad_pattern), 32'b0100);
        check("s4_valid", 32'(digit_valid), 32'b1011);
        check("s4_value", 32'(value), 32'hFBA1);

        // 5: blanking and multi-hot never accept
        cap_cnt = 0; frm_cnt = 0;
        hold(4'b0000, 7'b1111111, 1'b0, 10);
        hold(4'b0011, 7'b1111111, 1'b0, 10);
        check("s5_caps", 32'(cap_cnt), 32'd0);
        check("s5_frames", 32'(frm_cnt), 32'd0);
        check("s5_value", 32'(value), 32'hFBA1);

        // 6: asynchronous reset mid-frame
        hold(4'b0001, 7'b1111110, 1'b0, 5);
        hold(4'b0010, 7'b0110011, 1'b0, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("s6_async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        frm_cnt = 0;
        hold(4'b0001, 7'b1011011, 1'b0, 5);
        hold(4'b0010, 7'b1011111, 1'b1, 5);
        check("s6_dp", 32'(dp_out), 32'b0010);
        hold(4'b0100, 7'b1110000, 1'b0, 5);
        check("s6_noframe", 32'(frm_cnt), 32'd0);
        hold(4'b1000, 7'b1111011, 1'b0, 5);
        check("s6_frame", 32'(frm_cnt), 32'd1);

        // Random scan bursts including short runs, illegal glyphs, blanking, multi-hot
        for (int b = 0; b < 120; b++) begin
            int r;
            logic [D-1:0] ds;
            logic [6:0] sg;
            r = int'($urandom_range(0, 9));
            if (r < 8)       ds = 4'(1 << (r % 4));
            else if (r == 8) ds = 4'b0000;
            else             ds = 4'b0101;
            if ($urandom_range(0, 3) == 0) sg = 7'($urandom);
            else                           sg = glyphs[$urandom_range(0, 15)];
            hold(ds, sg, 1'($urandom_range(0, 1)), int'($urandom_range(1, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
